// File: rtl/factory_dispatch_if.sv
// Request/response bundle for the factory dispatch stage.
// master: request producer and output consumer; slave: the dispatch stage itself.
interface factory_dispatch_if #(
  parameter int unsigned DEPTH  = 4,
  parameter int unsigned FAM_W  = 2,
  parameter int unsigned KIND_W = 2,
  parameter int unsigned ID_W   = 8
);
  localparam int unsigned CntW = $clog2(DEPTH) + 1;

  logic [FAM_W-1:0]  family_sel;
  logic              req_valid;
  logic              req_ready;
  logic [KIND_W-1:0] req_kind;
  logic              out_valid;
  logic              out_ready;
  logic [FAM_W-1:0]  out_family;
  logic [KIND_W-1:0] out_kind;
  logic [ID_W-1:0]   out_id;
  logic              err_bad_family;
  logic [CntW-1:0]   count;

  modport master (
    output family_sel, req_valid, req_kind, out_ready,
    input  req_ready, out_valid, out_family, out_kind, out_id, err_bad_family, count
  );

  modport slave (
    input  family_sel, req_valid, req_kind, out_ready,
    output req_ready, out_valid, out_family, out_kind, out_id, err_bad_family, count
  );
endinterface

// File: rtl/factory_dispatch.sv
// Factory dispatch stage: binds the active family and a sequential object ID to each
// accepted request and queues it for the downstream product builders.
module factory_dispatch #(
  parameter int unsigned DEPTH        = 4,
  parameter int unsigned NUM_FAMILIES = 2,
  parameter int unsigned FAM_W        = 2,
  parameter int unsigned KIND_W       = 2,
  parameter int unsigned ID_W         = 8
) (
  input  logic                clk,
  input  logic                rst_n,
  factory_dispatch_if.slave   bus
);
  localparam int unsigned PtrW    = $clog2(DEPTH);
  localparam int unsigned CntW    = PtrW + 1;
  localparam int unsigned FamCmpW = FAM_W + 1;
  localparam logic [CntW-1:0]    Full   = CntW'(DEPTH);
  // One extra bit so NUM_FAMILIES == 2^FAM_W still compares correctly.
  localparam logic [FamCmpW-1:0] NumFam = FamCmpW'(NUM_FAMILIES);

  logic [FAM_W-1:0]  fam_mem_q  [DEPTH];
  logic [KIND_W-1:0] kind_mem_q [DEPTH];
  logic [ID_W-1:0]   id_mem_q   [DEPTH];

  logic [PtrW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0] count_q, count_d;
  logic [ID_W-1:0] next_id_q, next_id_d;
  logic            err_q, err_d;

  logic ready, valid, accept, legal, push, pop;

  // Handshake decode; ready depends on registered occupancy only (no full bypass).
  always_comb begin
    ready  = (count_q != Full);
    valid  = (count_q != '0);
    accept = bus.req_valid && ready;
    legal  = ({1'b0, bus.family_sel} < NumFam);
    push   = accept && legal;
    pop    = valid && bus.out_ready;
  end

  // Next-state for pointers, occupancy, ID counter and error pulse.
  always_comb begin
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    count_d   = count_q;
    next_id_d = next_id_q;
    err_d     = accept && !legal;
    if (push) begin
      wr_ptr_d  = wr_ptr_q + PtrW'(1);
      next_id_d = next_id_q + ID_W'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + PtrW'(1);
    end
    case ({push, pop})
      2'b10:   count_d = count_q + CntW'(1);
      2'b01:   count_d = count_q - CntW'(1);
      default: count_d = count_q;
    endcase
  end

  // Control state registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      next_id_q <= '0;
      err_q     <= 1'b0;
    end else begin
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      count_q   <= count_d;
      next_id_q <= next_id_d;
      err_q     <= err_d;
    end
  end

  // Entry storage; cleared on reset so the head fields are never X.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        fam_mem_q[i]  <= '0;
        kind_mem_q[i] <= '0;
        id_mem_q[i]   <= '0;
      end
    end else if (push) begin
      fam_mem_q[wr_ptr_q]  <= bus.family_sel;
      kind_mem_q[wr_ptr_q] <= bus.req_kind;
      id_mem_q[wr_ptr_q]   <= next_id_q;
    end
  end

  // Output drive from registered state.
  always_comb begin
    bus.req_ready      = ready;
    bus.out_valid      = valid;
    bus.out_family     = fam_mem_q[rd_ptr_q];
    bus.out_kind       = kind_mem_q[rd_ptr_q];
    bus.out_id         = id_mem_q[rd_ptr_q];
    bus.err_bad_family = err_q;
    bus.count          = count_q;
  end
endmodule

// File: tb/tb_factory_dispatch.sv
// Bench for factory_dispatch: fixed vector table, directed corner sequences and random
// traffic, all checked against a queue-based reference model.
module tb_factory_dispatch;
  localparam int unsigned DEPTH        = 4;
  localparam int unsigned NUM_FAMILIES = 2;
  localparam int unsigned FAM_W        = 2;
  localparam int unsigned KIND_W       = 2;
  localparam int unsigned ID_W         = 8;

  logic clk;
  logic rst_n;
  int   total = 0;
  int   bad   = 0;

  factory_dispatch_if #(
    .DEPTH  (DEPTH),
    .FAM_W  (FAM_W),
    .KIND_W (KIND_W),
    .ID_W   (ID_W)
  ) bus ();

  factory_dispatch #(
    .DEPTH        (DEPTH),
    .NUM_FAMILIES (NUM_FAMILIES),
    .FAM_W        (FAM_W),
    .KIND_W       (KIND_W),
    .ID_W         (ID_W)
  ) u_dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: queued entries, next ID, pending error pulse.
  typedef struct {
    int fam;
    int kind;
    int id;
  } ent_t;

  ent_t mq[$];
  int   m_id  = 0;
  bit   m_err = 1'b0;

  typedef struct {
    bit v;
    int fam;
    int kind;
    bit ordy;
    bit e_valid;
    int e_fam;
    int e_kind;
    int e_id;
    int e_cnt;
    bit e_rdy;
    bit e_err;
  } vec_t;

  vec_t tbl[10];

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic drive(input bit v, input int fam, input int kind, input bit ordy);
    bus.req_valid  = v;
    bus.family_sel = FAM_W'(fam);
    bus.req_kind   = KIND_W'(kind);
    bus.out_ready  = ordy;
  endtask

  task automatic model_check(input string tag);
    chk({tag, "_out_valid"}, int'(bus.out_valid), int'(mq.size() > 0));
    chk({tag, "_count"}, int'(bus.count), mq.size());
    chk({tag, "_req_ready"}, int'(bus.req_ready), int'(mq.size() != DEPTH));
    chk({tag, "_err"}, int'(bus.err_bad_family), int'(m_err));
    if (mq.size() > 0) begin
      chk({tag, "_out_family"}, int'(bus.out_family), mq[0].fam);
      chk({tag, "_out_kind"}, int'(bus.out_kind), mq[0].kind);
      chk({tag, "_out_id"}, int'(bus.out_id), mq[0].id);
    end
  endtask

  // One clock: the model applies the pre-edge inputs to the pre-edge queue, then compares.
  task automatic cycle(input string tag);
    bit   acc;
    bit   lgl;
    bit   pp;
    ent_t e;
    acc = bus.req_valid && (mq.size() != DEPTH);
    lgl = int'(bus.family_sel) < NUM_FAMILIES;
    pp  = (mq.size() > 0) && bus.out_ready;
    e.fam  = int'(bus.family_sel);
    e.kind = int'(bus.req_kind);
    e.id   = m_id;
    @(posedge clk);
    if (pp) void'(mq.pop_front());
    if (acc && lgl) begin
      mq.push_back(e);
      m_id = (m_id + 1) % (1 << ID_W);
    end
    m_err = acc && !lgl;
    #1;
    model_check(tag);
  endtask

  // Asynchronous assert away from the clock edge; release on the following falling edge.
  task automatic do_reset();
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    mq.delete();
    m_id  = 0;
    m_err = 1'b0;
    #1;
    chk("rst_out_valid", int'(bus.out_valid), 0);
    chk("rst_count", int'(bus.count), 0);
    chk("rst_req_ready", int'(bus.req_ready), 1);
    chk("rst_err", int'(bus.err_bad_family), 0);
    drive(1'b0, 0, 0, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n = 1'b0;
    drive(1'b0, 0, 0, 1'b0);

    //            v fam kind ordy | valid fam kind id cnt rdy err
    tbl[0] = '{1'b1, 1, 2, 1'b0, 1'b1, 1, 2, 0, 1, 1'b1, 1'b0};
    tbl[1] = '{1'b1, 3, 1, 1'b0, 1'b1, 1, 2, 0, 1, 1'b1, 1'b1};
    tbl[2] = '{1'b1, 0, 3, 1'b0, 1'b1, 1, 2, 0, 2, 1'b1, 1'b0};
    tbl[3] = '{1'b1, 3, 0, 1'b0, 1'b1, 1, 2, 0, 2, 1'b1, 1'b1};
    tbl[4] = '{1'b1, 3, 0, 1'b0, 1'b1, 1, 2, 0, 2, 1'b1, 1'b1};
    tbl[5] = '{1'b0, 0, 0, 1'b0, 1'b1, 1, 2, 0, 2, 1'b1, 1'b0};
    tbl[6] = '{1'b1, 1, 1, 1'b1, 1'b1, 0, 3, 1, 2, 1'b1, 1'b0};
    tbl[7] = '{1'b0, 0, 0, 1'b1, 1'b1, 1, 1, 2, 1, 1'b1, 1'b0};
    tbl[8] = '{1'b0, 0, 0, 1'b1, 1'b0, 0, 0, 0, 0, 1'b1, 1'b0};
    tbl[9] = '{1'b0, 0, 0, 1'b1, 1'b0, 0, 0, 0, 0, 1'b1, 1'b0};

    #12;
    chk("init_out_valid", int'(bus.out_valid), 0);
    chk("init_count", int'(bus.count), 0);
    chk("init_req_ready", int'(bus.req_ready), 1);
    chk("init_err", int'(bus.err_bad_family), 0);
    chk("init_out_no_x", int'($isunknown({bus.out_family, bus.out_kind, bus.out_id})), 0);
    @(negedge clk);
    rst_n = 1'b1;

    // Vector table: first request, interleaved illegal families, push+pop, drain.
    for (int i = 0; i < 10; i++) begin
      drive(tbl[i].v, tbl[i].fam, tbl[i].kind, tbl[i].ordy);
      cycle($sformatf("tbl%0d", i));
      chk($sformatf("tbl%0d_valid", i), int'(bus.out_valid), int'(tbl[i].e_valid));
      chk($sformatf("tbl%0d_cnt", i), int'(bus.count), tbl[i].e_cnt);
      chk($sformatf("tbl%0d_rdy", i), int'(bus.req_ready), int'(tbl[i].e_rdy));
      chk($sformatf("tbl%0d_err", i), int'(bus.err_bad_family), int'(tbl[i].e_err));
      if (tbl[i].e_valid) begin
        chk($sformatf("tbl%0d_fam", i), int'(bus.out_family), tbl[i].e_fam);
        chk($sformatf("tbl%0d_kind", i), int'(bus.out_kind), tbl[i].e_kind);
        chk($sformatf("tbl%0d_id", i), int'(bus.out_id), tbl[i].e_id);
      end
    end

    // Fill to full, hold a fifth request, single pop without same-cycle push.
    do_reset();
    for (int k = 0; k < 4; k++) begin
      drive(1'b1, 0, k, 1'b0);
      cycle("fill");
    end
    chk("full_count", int'(bus.count), 4);
    chk("full_ready", int'(bus.req_ready), 0);
    cycle("held5");
    chk("held5_count", int'(bus.count), 4);
    drive(1'b1, 0, 1, 1'b1);
    cycle("pop_full");
    chk("pop_full_count", int'(bus.count), 3);
    chk("pop_full_ready", int'(bus.req_ready), 1);
    drive(1'b1, 0, 1, 1'b0);
    cycle("refill");
    chk("refill_count", int'(bus.count), 4);
    drive(1'b0, 0, 0, 1'b1);
    for (int k = 0; k < 4; k++) begin
      chk("drain_id", int'(bus.out_id), k + 1);
      cycle("drain");
    end

    // Streaming: one accept and one pop per cycle, IDs wrap through 255.
    do_reset();
    drive(1'b1, 0, 0, 1'b1);
    for (int k = 0; k < 300; k++) begin
      bus.req_kind = KIND_W'(k % 4);
      cycle("stream");
      chk("stream_id", int'(bus.out_id), k % 256);
      chk("stream_cnt", int'(bus.count), 1);
    end
    drive(1'b0, 0, 0, 1'b1);
    cycle("stream_end");

    // Family change with entries already queued.
    do_reset();
    drive(1'b1, 0, 1, 1'b0);
    cycle("famq");
    cycle("famq");
    drive(1'b1, 1, 2, 1'b0);
    cycle("famq");
    drive(1'b0, 1, 0, 1'b1);
    for (int k = 0; k < 3; k++) begin
      chk("famchg_family", int'(bus.out_family), (k < 2) ? 0 : 1);
      cycle("famchg");
    end

    // Asynchronous reset with three entries queued; ID restarts at 0.
    drive(1'b1, 1, 3, 1'b0);
    for (int k = 0; k < 3; k++) cycle("prerst");
    chk("prerst_count", int'(bus.count), 3);
    do_reset();
    drive(1'b1, 1, 2, 1'b0);
    cycle("postrst");
    chk("postrst_id", int'(bus.out_id), 0);
    chk("postrst_cnt", int'(bus.count), 1);

    // Random traffic, first with slow then with eager consumer.
    do_reset();
    for (int k = 0; k < 3000; k++) begin
      drive(1'($urandom_range(0, 1)), int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
            (k < 1500) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 3) != 0));
      cycle("rand");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
